// File: rtl/sha_round_counter.sv
// sha_round_counter: round/address sequencer for the hash core.
// Steps addr through 0..ROUNDS-1 and drives the K-ROM address. It supports
// stall and restart, and uses a start/done/read handshake (eoc held until rd).
// Optional build macro SHA_CNT_WINDOW_EN adds the w_idx/w_sched
// message-schedule window outputs.
module sha_round_counter #(
  parameter int ROUNDS = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              eoc,
  output logic              first,
  output logic              last
`ifdef SHA_CNT_WINDOW_EN
  ,
  output logic [3:0]        w_idx,
  output logic              w_sched
`endif
);

  // Final round index, and the index just before it (used to pre-compute last).
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(ROUNDS - 1);
  localparam logic [ADDR_W-1:0] LAST_M1 = ADDR_W'(ROUNDS - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Sequencer FSM.
  // Every flag is registered alongside the state, so no input reaches an
  // output combinationally. addr is forced to 0 outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      busy  <= 1'b0;
      eoc   <= 1'b0;
      first <= 1'b0;
      last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            addr  <= '0;
            busy  <= 1'b1;
            eoc   <= 1'b0;
            first <= 1'b1;
            last  <= 1'b0;
          end
        end
        RUN: begin
          if (start) begin
            // A restart takes precedence over a stall.
            addr  <= '0;
            first <= 1'b1;
            last  <= 1'b0;
          end else if (stall) begin
            // Hold addr and all flags unchanged.
          end else if (addr < LAST) begin
            addr  <= addr + ADDR_W'(1);
            first <= 1'b0;
            last  <= (addr == LAST_M1);
          end else begin
            state <= DONE;
            addr  <= '0;
            busy  <= 1'b0;
            eoc   <= 1'b1;
            first <= 1'b0;
            last  <= 1'b0;
          end
        end
        DONE: begin
          if (start) begin
            // A new block wins over the read acknowledge; eoc drops on this edge.
            state <= RUN;
            addr  <= '0;
            busy  <= 1'b1;
            eoc   <= 1'b0;
            first <= 1'b1;
            last  <= 1'b0;
          end else if (rd) begin
            state <= IDLE;
            eoc   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          addr  <= '0;
          busy  <= 1'b0;
          eoc   <= 1'b0;
          first <= 1'b0;
          last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHA_CNT_WINDOW_EN
  // Zero-extend addr so the window decode also works when ADDR_W < 5.
  logic [31:0] addr_w;

  // Window decode from the registered addr and busy.
  // w_idx is the slot in the circular 16-word W buffer.
  // addr is 0 in IDLE and DONE, so both outputs read 0 there.
  always_comb begin
    addr_w  = 32'(addr);
    w_idx   = addr_w[3:0];
    w_sched = busy & (|addr_w[31:4]);
  end
`endif

endmodule

// File: tb/tb_sha_round_counter.sv
// Scoreboard bench for sha_round_counter (ROUNDS=64/ADDR_W=6 and ROUNDS=80/ADDR_W=7).
// The stimulus pushes the hand-derived expected outputs per cycle.
// A monitor pops and compares them on the falling edge.
module tb_sha_round_counter;

  logic clk, rst, start, stall, rd;
  logic [5:0] a64;
  logic       b64, e64, f64, l64;
  logic [6:0] a80;
  logic       b80, e80, f80, l80;
`ifdef SHA_CNT_WINDOW_EN
  logic [3:0] wi64, wi80;
  logic       ws64, ws80;
`endif

  sha_round_counter #(.ROUNDS(64), .ADDR_W(6)) dut64 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .rd(rd),
    .addr(a64), .busy(b64), .eoc(e64), .first(f64), .last(l64)
`ifdef SHA_CNT_WINDOW_EN
    , .w_idx(wi64), .w_sched(ws64)
`endif
  );

  sha_round_counter #(.ROUNDS(80), .ADDR_W(7)) dut80 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .rd(rd),
    .addr(a80), .busy(b80), .eoc(e80), .first(f80), .last(l80)
`ifdef SHA_CNT_WINDOW_EN
    , .w_idx(wi80), .w_sched(ws80)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   sel;
    int   addr;
    logic busy;
    logic eoc;
    logic first;
    logic last;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    errors = 0;
  int    checks = 0;

  // Monitor-side working variables.
  exp_t  me;
  string mn;
  int    ma;
  logic  mb, mo, mf, ml;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      mn = nq.pop_front();
      if (me.sel == 0) begin
        ma = int'(a64); mb = b64; mo = e64; mf = f64; ml = l64;
      end else begin
        ma = int'(a80); mb = b80; mo = e80; mf = f80; ml = l80;
      end
      checks++;
      if (ma !== me.addr || mb !== me.busy || mo !== me.eoc || mf !== me.first || ml !== me.last) begin
        errors++;
        $display("FAIL %s: got addr=%0d busy=%b eoc=%b first=%b last=%b, want addr=%0d busy=%b eoc=%b first=%b last=%b",
                 mn, ma, mb, mo, mf, ml, me.addr, me.busy, me.eoc, me.first, me.last);
      end
`ifdef SHA_CNT_WINDOW_EN
      if (me.sel == 0) begin
        checks++;
        if (int'(wi64) !== (me.addr % 16) || ws64 !== (me.busy && me.addr >= 16)) begin
          errors++;
          $display("FAIL %s_win: got w_idx=%0d w_sched=%b, want w_idx=%0d w_sched=%b",
                   mn, wi64, ws64, me.addr % 16, (me.busy && me.addr >= 16));
        end
      end
`endif
    end
  end

  // Drive one cycle of inputs, then queue the expected post-edge outputs.
  task automatic step(input logic r, input logic s, input logic st, input logic d,
                      input int sel, input int ea, input logic eb, input logic ee,
                      input logic ef, input logic el, input string nm);
    exp_t e;
    rst = r; start = s; stall = st; rd = d;
    @(posedge clk);
    #1;
    e.sel = sel; e.addr = ea; e.busy = eb; e.eoc = ee; e.first = ef; e.last = el;
    q.push_back(e);
    nq.push_back(nm);
    @(negedge clk);
  endtask

  // Expect RUN at round a of an R-round block.
  task automatic run(input int sel, input int R, input int a, input logic s,
                     input logic st, input logic d, input string nm);
    step(1'b0, s, st, d, sel, a, 1'b1, 1'b0, (a == 0), (a == R - 1), nm);
  endtask

  // Expect IDLE.
  task automatic idle(input int sel, input logic r, input logic s, input logic st,
                      input logic d, input string nm);
    step(r, s, st, d, sel, 0, 1'b0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  // Expect DONE.
  task automatic done(input int sel, input logic s, input logic d, input string nm);
    step(1'b0, s, 1'b0, d, sel, 0, 1'b0, 1'b1, 1'b0, 1'b0, nm);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; rd = 1'b0;
    @(negedge clk);

    // 1: reset dominates start
    idle(0, 1'b1, 1'b1, 1'b0, 1'b0, "rst_c1");
    idle(0, 1'b1, 1'b1, 1'b0, 1'b0, "rst_c2");
    idle(1, 1'b1, 1'b1, 1'b0, 1'b0, "rst80");
    // IDLE ignores stall and rd
    idle(0, 1'b0, 1'b0, 1'b1, 1'b1, "idle_ign");

    // 2: plain 64-round block, eoc held for 10 cycles, then read
    run(0, 64, 0, 1'b1, 1'b0, 1'b0, "t2_start");
    for (int i = 1; i < 64; i++) run(0, 64, i, 1'b0, 1'b0, 1'b0, "t2_run");
    done(0, 1'b0, 1'b0, "t2_eoc");
    for (int i = 0; i < 9; i++) done(0, 1'b0, 1'b0, "t2_hold");
    idle(0, 1'b0, 1'b0, 1'b0, 1'b1, "t2_rd");
    idle(0, 1'b0, 1'b0, 1'b0, 1'b0, "t2_idle");

    // 3: three stall cycles at addr 17
    run(0, 64, 0, 1'b1, 1'b0, 1'b0, "t3_start");
    for (int i = 1; i <= 17; i++) run(0, 64, i, 1'b0, 1'b0, 1'b0, "t3_run");
    for (int i = 0; i < 3; i++) run(0, 64, 17, 1'b0, 1'b1, 1'b0, "t3_stall");
    for (int i = 18; i < 64; i++) run(0, 64, i, 1'b0, 1'b0, 1'b0, "t3_run2");
    done(0, 1'b0, 1'b0, "t3_eoc");
    idle(0, 1'b0, 1'b0, 1'b0, 1'b1, "t3_rd");

    // 4: restart at 40, start beats stall, start beats rd in DONE
    run(0, 64, 0, 1'b1, 1'b0, 1'b0, "t4_start");
    for (int i = 1; i <= 40; i++) run(0, 64, i, 1'b0, 1'b0, 1'b0, "t4_run");
    run(0, 64, 0, 1'b1, 1'b0, 1'b0, "t4_restart");
    for (int i = 1; i <= 5; i++) run(0, 64, i, 1'b0, 1'b0, 1'b0, "t4_run2");
    run(0, 64, 0, 1'b1, 1'b1, 1'b0, "t4_start_stall");
    for (int i = 1; i < 64; i++) run(0, 64, i, 1'b0, 1'b0, 1'b0, "t4_run3");
    done(0, 1'b0, 1'b0, "t4_eoc");
    run(0, 64, 0, 1'b1, 1'b0, 1'b1, "t4_start_rd");
    run(0, 64, 1, 1'b0, 1'b0, 1'b1, "t4_rd_in_run");
    // reset mid-run aborts with no eoc
    idle(0, 1'b1, 1'b0, 1'b0, 1'b0, "t4_rst_mid");
    idle(0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_after_rst");

    // 5: 80-round instance
    idle(1, 1'b1, 1'b0, 1'b0, 1'b0, "t5_rst");
    run(1, 80, 0, 1'b1, 1'b0, 1'b0, "t5_start");
    for (int i = 1; i < 80; i++) run(1, 80, i, 1'b0, 1'b0, 1'b0, "t5_run");
    done(1, 1'b0, 1'b0, "t5_eoc");
    done(1, 1'b0, 1'b0, "t5_hold");
    idle(1, 1'b0, 1'b0, 1'b0, 1'b1, "t5_rd");

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
